// File: rtl/screen_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer_pkg
//  Description : Shared display definitions for the maze game screen flow.
//                Holds the screen state encoding, the return target stored
//                across the post-draw gap, result codes (also read by the HUD
//                block) and default timing parameters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package screen_sequencer_pkg;

   // Default result-screen display time: 1 s at 50 MHz.
   localparam int unsigned DEFAULT_HOLD_CYCLES = 50_000_000;
   localparam int unsigned DEFAULT_CNT_W       = 26;

   typedef enum logic [3:0] {
      ST_BOOT       = 4'd0,
      ST_DRAW_START = 4'd1,
      ST_TITLE      = 4'd2,
      ST_DRAW_CLEAR = 4'd3,
      ST_PLAY       = 4'd4,
      ST_DRAW_WIN   = 4'd5,
      ST_DRAW_OVER  = 4'd6,
      ST_GAP        = 4'd7,
      ST_HOLD       = 4'd8,
      ST_END_WAIT   = 4'd9
   } screen_state_e;

   // Where the sequencer goes once the drawing block has released done.
   typedef enum logic [1:0] {
      RET_TITLE = 2'd0,
      RET_PLAY  = 2'd1,
      RET_HOLD  = 2'd2
   } gap_ret_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_WIN  = 2'b01,
      RES_LOSE = 2'b10
   } result_e;

   function automatic screen_state_e ret_to_state(input gap_ret_e ret);
      screen_state_e st;
      case (ret)
         RET_TITLE: st = ST_TITLE;
         RET_PLAY:  st = ST_PLAY;
         RET_HOLD:  st = ST_HOLD;
         default:   st = ST_BOOT;
      endcase
      return st;
   endfunction

endpackage : screen_sequencer_pkg
`default_nettype wire

// File: rtl/screen_sequencer_rise.sv
`default_nettype none
// ============================================================================
//  Module      : rise_detect
//  Description : 1-bit registered rising-edge detector with synchronous reset.
//                rise_o is high for the single cycle in which level_i is high
//                and was low on the previous clock edge.
//  Ports       : clk      - system clock
//                reset    - synchronous active-high reset (clears history)
//                level_i  - synchronised input level
//                rise_o   - combinational rising-edge strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_i;
      end
   end

   assign rise_o = level_i & ~prev_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : screen_sequencer
//  Description : Screen-flow controller for the maze game. Initiator side of
//                the full-screen draw handshake (one request at a time, held
//                until done, then all requests low until done clears), plus
//                title -> play -> result flow and VGA plot gating.
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous active-high reset
//                gameStart    - start button level (rising edge = request)
//                playerWin    - player reached the exit
//                playerDead   - player lost
//                drawDone     - done from the screen drawing block
//                drawStart    - request: draw title screen
//                drawClear    - request: clear screen for play
//                drawGameOver - request: draw game-over screen
//                drawWinner   - request: draw winner screen
//                plot         - VGA write enable during full-screen draws
//                gameActive   - high only while playing
//                result       - 00 none, 01 win, 10 lose
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_sequencer
   import screen_sequencer_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       gameStart,
   input  logic       playerWin,
   input  logic       playerDead,
   input  logic       drawDone,
   output logic       drawStart,
   output logic       drawClear,
   output logic       drawGameOver,
   output logic       drawWinner,
   output logic       plot,
   output logic       gameActive,
   output logic [1:0] result
);

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   screen_state_e    state_q,  state_d;
   gap_ret_e         ret_q,    ret_d;
   logic [1:0]       result_q, result_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             w_gs_rise;

   // Only a fresh press counts: a button already held when TITLE or
   // END_WAIT is entered has no edge and is ignored.
   rise_detect u_gs_rise (
      .clk     (clk),
      .reset   (reset),
      .level_i (gameStart),
      .rise_o  (w_gs_rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_BOOT;
         ret_q    <= RET_TITLE;
         result_q <= RES_NONE;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ret_d        = ret_q;
      result_d     = result_q;
      cnt_d        = '0;          // counter only runs while in HOLD
      drawStart    = 1'b0;
      drawClear    = 1'b0;
      drawGameOver = 1'b0;
      drawWinner   = 1'b0;
      gameActive   = 1'b0;

      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_DRAW_START;
         end

         ST_DRAW_START: begin
            drawStart = 1'b1;
            if (drawDone) begin
               state_d = ST_GAP;
               ret_d   = RET_TITLE;
            end
         end

         ST_TITLE: begin
            if (w_gs_rise) begin
               state_d  = ST_DRAW_CLEAR;
               result_d = RES_NONE;
            end
         end

         ST_DRAW_CLEAR: begin
            drawClear = 1'b1;
            if (drawDone) begin
               state_d = ST_GAP;
               ret_d   = RET_PLAY;
            end
         end

         ST_PLAY: begin
            gameActive = 1'b1;
            // Win takes priority when both events land in the same cycle.
            if (playerWin) begin
               state_d  = ST_DRAW_WIN;
               result_d = RES_WIN;
            end else if (playerDead) begin
               state_d  = ST_DRAW_OVER;
               result_d = RES_LOSE;
            end
         end

         ST_DRAW_WIN: begin
            drawWinner = 1'b1;
            if (drawDone) begin
               state_d = ST_GAP;
               ret_d   = RET_HOLD;
            end
         end

         ST_DRAW_OVER: begin
            drawGameOver = 1'b1;
            if (drawDone) begin
               state_d = ST_GAP;
               ret_d   = RET_HOLD;
            end
         end

         // Wait for the drawing block to drop done so its counters are
         // rearmed before the next request can be raised.
         ST_GAP: begin
            if (!drawDone) begin
               state_d = ret_to_state(ret_q);
            end
         end

         ST_HOLD: begin
            if (cnt_q == C_HOLD_LAST) begin
               state_d = ST_END_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_END_WAIT: begin
            if (w_gs_rise) begin
               state_d = ST_DRAW_START;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Plot is low in the cycle done is seen so the drawing block's final
   // address is not written twice.
   assign plot   = (drawStart | drawClear | drawGameOver | drawWinner) & ~drawDone;
   assign result = result_q;

endmodule : screen_sequencer
`default_nettype wire

// File: tb/tb_screen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_screen_sequencer
//  Description : Self-checking bench for screen_sequencer. A behavioural
//                drawing-block model answers requests after random latencies;
//                expected outputs follow from the screen-flow rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_sequencer;

   localparam int unsigned HOLD = 8;
   localparam logic [3:0] REQ_NONE  = 4'b0000;
   localparam logic [3:0] REQ_START = 4'b1000;
   localparam logic [3:0] REQ_CLEAR = 4'b0100;
   localparam logic [3:0] REQ_OVER  = 4'b0010;
   localparam logic [3:0] REQ_WIN   = 4'b0001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic gameStart = 1'b0;
   logic playerWin = 1'b0;
   logic playerDead = 1'b0;
   logic drawDone = 1'b0;
   logic drawStart, drawClear, drawGameOver, drawWinner, plot, gameActive;
   logic [1:0] result;
   logic [3:0] req;
   logic [1:0] exp_result;

   int checks = 0;
   int errors = 0;

   assign req = {drawStart, drawClear, drawGameOver, drawWinner};

   always #5 clk = ~clk;

   screen_sequencer #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .gameStart    (gameStart),
      .playerWin    (playerWin),
      .playerDead   (playerDead),
      .drawDone     (drawDone),
      .drawStart    (drawStart),
      .drawClear    (drawClear),
      .drawGameOver (drawGameOver),
      .drawWinner   (drawWinner),
      .plot         (plot),
      .gameActive   (gameActive),
      .result       (result)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drawing-block model: keeps done low for lat cycles while the request is
   // up, raises done for one cycle, then holds done for gap_hold extra cycles.
   task automatic serve_draw(input logic [3:0] exp_req, input int lat,
                             input int gap_hold, input string tag);
      for (int k = 0; k < lat; k++) begin
         drawDone = 1'b0;
         #1;
         checks++;
         if (req !== exp_req) begin
            errors++; $display("FAIL %s_req_busy: got %b expected %b", tag, req, exp_req);
         end
         checks++;
         if (plot !== 1'b1) begin
            errors++; $display("FAIL %s_plot_busy: got %b expected 1", tag, plot);
         end
         next_cycle();
      end
      drawDone = 1'b1;
      #1;
      checks++;
      if (req !== exp_req) begin
         errors++; $display("FAIL %s_req_done: got %b expected %b", tag, req, exp_req);
      end
      checks++;
      if (plot !== 1'b0) begin
         errors++; $display("FAIL %s_plot_done: got %b expected 0", tag, plot);
      end
      next_cycle();
      for (int g = 0; g < gap_hold; g++) begin
         drawDone = 1'b1;
         #1;
         checks++;
         if (req !== REQ_NONE || plot !== 1'b0) begin
            errors++; $display("FAIL %s_gap_hold: got req=%b plot=%b expected req=0000 plot=0", tag, req, plot);
         end
         next_cycle();
      end
      drawDone = 1'b0;
      #1;
      checks++;
      if (req !== REQ_NONE || plot !== 1'b0) begin
         errors++; $display("FAIL %s_gap_end: got req=%b plot=%b expected req=0000 plot=0", tag, req, plot);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      checks++;
      if (req !== REQ_NONE || plot !== 1'b0 || gameActive !== 1'b0 || result !== 2'b00) begin
         errors++; $display("FAIL reset_outputs: got req=%b plot=%b act=%b res=%b expected all 0",
                            req, plot, gameActive, result);
      end
      next_cycle();
      serve_draw(REQ_START, 9, 0, "boot_start");
      #1;
      checks++;
      if (req !== REQ_NONE || gameActive !== 1'b0) begin
         errors++; $display("FAIL reset_title: got req=%b act=%b expected 0000/0", req, gameActive);
      end
      exp_result = 2'b00;
   endtask

   // From TITLE: random ignored noise, one-cycle press, serve the clear.
   task automatic test_title_start(input int gap_hold);
      int n;
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
         gameStart = 1'b0;
         playerWin = 1'($urandom);
         playerDead = 1'($urandom);
         #1;
         checks++;
         if (req !== REQ_NONE || gameActive !== 1'b0) begin
            errors++; $display("FAIL title_idle: got req=%b act=%b expected 0000/0", req, gameActive);
         end
         next_cycle();
      end
      playerWin = 1'b0;
      playerDead = 1'b0;
      gameStart = 1'b1;
      next_cycle();
      gameStart = 1'b0;
      #1;
      exp_result = 2'b00;
      checks++;
      if (req !== REQ_CLEAR || result !== exp_result) begin
         errors++; $display("FAIL title_press: got req=%b res=%b expected req=%b res=%b",
                            req, result, REQ_CLEAR, exp_result);
      end
      serve_draw(REQ_CLEAR, $urandom_range(0, 5),
                 (gap_hold < 0) ? int'($urandom_range(0, 2)) : gap_hold, "clear");
      #1;
      checks++;
      if (gameActive !== 1'b1 || req !== REQ_NONE || result !== exp_result) begin
         errors++; $display("FAIL play_entry: got act=%b req=%b res=%b expected 1/0000/%b",
                            gameActive, req, result, exp_result);
      end
   endtask

   // From PLAY: kind 0 win, 1 dead, 2 both. mode 0 press on last HOLD cycle,
   // mode 1 press on first END_WAIT cycle, mode 2 button held through HOLD.
   task automatic test_play_result(input int kind, input int mode);
      int n;
      logic [3:0] exp_req;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
         gameStart = 1'($urandom);
         #1;
         checks++;
         if (gameActive !== 1'b1 || req !== REQ_NONE) begin
            errors++; $display("FAIL play_idle: got act=%b req=%b expected 1/0000", gameActive, req);
         end
         next_cycle();
      end
      gameStart = (mode == 2);
      playerWin = (kind != 1);
      playerDead = (kind != 0);
      next_cycle();
      playerWin = 1'b0;
      playerDead = 1'b0;
      exp_req = (kind != 1) ? REQ_WIN : REQ_OVER;
      exp_result = (kind != 1) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req !== exp_req || result !== exp_result || gameActive !== 1'b0) begin
         errors++; $display("FAIL play_event: got req=%b res=%b act=%b expected req=%b res=%b act=0",
                            req, result, gameActive, exp_req, exp_result);
      end
      serve_draw(exp_req, $urandom_range(0, 5), $urandom_range(0, 2), "result");
      for (int i = 0; i < int'(HOLD) - 1; i++) begin
         playerWin = 1'($urandom);
         playerDead = 1'($urandom);
         #1;
         checks++;
         if (req !== REQ_NONE || gameActive !== 1'b0) begin
            errors++; $display("FAIL hold_idle: got req=%b act=%b expected 0000/0", req, gameActive);
         end
         next_cycle();
      end
      playerWin = 1'b0;
      playerDead = 1'b0;
      if (mode == 0) begin
         gameStart = 1'b1;           // last HOLD cycle: must be ignored
         next_cycle();
         gameStart = 1'b0;
         #1;
         checks++;
         if (req !== REQ_NONE) begin
            errors++; $display("FAIL hold_press_ignored: got req=%b expected 0000", req);
         end
         next_cycle();
      end else if (mode == 1) begin
         next_cycle();
      end else begin
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req !== REQ_NONE) begin
               errors++; $display("FAIL held_level_ignored: got req=%b expected 0000", req);
            end
            next_cycle();
         end
         gameStart = 1'b0;
         next_cycle();
      end
      gameStart = 1'b1;
      #1;
      checks++;
      if (req !== REQ_NONE) begin
         errors++; $display("FAIL end_wait_before: got req=%b expected 0000", req);
      end
      next_cycle();
      gameStart = 1'b0;
      #1;
      checks++;
      if (req !== REQ_START || result !== exp_result) begin
         errors++; $display("FAIL end_wait_press: got req=%b res=%b expected req=%b res=%b",
                            req, result, REQ_START, exp_result);
      end
      serve_draw(REQ_START, $urandom_range(0, 5), $urandom_range(0, 2), "restart");
   endtask

   task automatic test_gap_extend();
      test_title_start(3);
   endtask

   task automatic test_reset_mid_draw();
      playerDead = 1'b1;
      next_cycle();
      playerDead = 1'b0;
      drawDone = 1'b0;
      #1;
      checks++;
      if (drawGameOver !== 1'b1 || plot !== 1'b1 || result !== 2'b10) begin
         errors++; $display("FAIL mid_draw_over: got over=%b plot=%b res=%b expected 1/1/10",
                            drawGameOver, plot, result);
      end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      #1;
      checks++;
      if (req !== REQ_NONE || plot !== 1'b0 || gameActive !== 1'b0 || result !== 2'b00) begin
         errors++; $display("FAIL mid_draw_reset: got req=%b plot=%b act=%b res=%b expected all 0",
                            req, plot, gameActive, result);
      end
      reset = 1'b0;
      next_cycle();
      #1;
      checks++;
      if (req !== REQ_START) begin
         errors++; $display("FAIL mid_draw_restart: got req=%b expected %b", req, REQ_START);
      end
      serve_draw(REQ_START, $urandom_range(0, 5), 0, "restart2");
      exp_result = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_title_start(-1);
      test_play_result(2, 0);
      test_title_start(-1);
      test_play_result(1, 1);
      test_title_start(-1);
      test_play_result(0, 2);
      test_gap_extend();
      test_reset_mid_draw();
      for (int r = 0; r < 5; r++) begin
         test_title_start(-1);
         test_play_result(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_screen_sequencer
`default_nettype wire
